bp_writeback_control: RTL and testbench
=======================================

Name: bp_writeback_control

Overview:
- Reverse path of the BP load controller: reads two consecutive BP buffer banks and streams the 512-bit rows into the DDR write FIFO.
- One configuration moves 2*Line_width rows: bank BP_st_num, then bank BP_st_num+1 (mod 4), addresses BP_st_addr .. BP_st_addr+Line_width-1 in each bank.
- Sits between the BP buffer array (read ports) and the DDR write engine, and issues that engine its address/length command.

Parameters:
- X_MAC, 4: banks per mesh column; one bank is selected per line.
- X_MESH, 16: columns; one DATA_LEN word per column per row.
- DDR_ADDR_LEN, 32: DDR address width.
- ADDR_LEN, 16: BP buffer address width.
- DATA_LEN, 32: word width; a row is DATA_LEN*16 = 512 bits.
- SINGLE_LEN, 24: length/count width.
- BUFFER_NUM, 64: number of buffers; buffer index = bank + 4*column.
- RD_LAT, 2: cycles from BP_rd_en to valid BP_data_in.
- SKID_DEPTH, 4: internal row buffer depth; must be >= RD_LAT+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- conf  in  1  start pulse; accepted only when idle=1.
- data_ddr_byte  in  SINGLE_LEN  DDR write length in bytes.
- ddr_st_addr  in  DDR_ADDR_LEN  DDR write start address.
- BP_st_addr  in  ADDR_LEN  first BP address of each line.
- BP_st_num  in  2  first bank index.
- Line_width  in  SINGLE_LEN  rows per line.
- ddr_st_addr_out  out  DDR_ADDR_LEN  latched DDR address.
- ddr_len  out  SINGLE_LEN  latched byte length.
- ddr_conf  out  1  command strobe to the DDR write engine.
- BP_addr_out  out  ADDR_LEN*BUFFER_NUM  read address, replicated to all buffers.
- BP_rd_en  out  BUFFER_NUM  per-buffer read enable.
- BP_data_in  in  DATA_LEN*BUFFER_NUM  buffer read data.
- ddr_wfifo_full  in  1  DDR write FIFO full.
- ddr_wfifo_we  out  1  write strobe.
- ddr_wfifo_data  out  DATA_LEN*16  row data; word j = column j.
- idle  out  1  high when no transfer is active or pending.

Behaviour:
- Reset: all outputs 0, except idle=1. Internal state returns to IDLE; skid buffer and counters are cleared. Reset asserted mid-transfer abandons the transfer and does not drain the skid buffer.
- States are IDLE, READ and DRAIN.
- IDLE with conf=1 and Line_width!=0:
  - Latch all inputs.
  - Register ddr_st_addr_out=ddr_st_addr and ddr_len=data_ddr_byte.
  - ddr_conf=1 for exactly one cycle, on the cycle after conf.
  - Go to READ.
- IDLE with conf=1 and Line_width==0: ddr_conf pulses as above, no reads are issued, and the block stays idle.
- conf outside IDLE is ignored.
- READ issues one read per cycle when (skid occupancy + reads in flight) < SKID_DEPTH:
  - BP_rd_en[bank+4*j]=1 for j=0..15, all other enables 0.
  - All BP_addr_out slices carry the current address.
  - Address increments per issued read.
  - After Line_width reads, the address reloads BP_st_addr and bank = BP_st_num+1 (2-bit wrap: 3 -> 0).
  - After 2*Line_width reads, go to DRAIN.
- Capture: RD_LAT cycles after an issue, word j = BP_data_in[(bank_issued+4*j)*DATA_LEN +: DATA_LEN] is pushed into the skid buffer. The bank is pipelined alongside the read.
- Output handshake:
  - ddr_wfifo_we = skid non-empty AND !ddr_wfifo_full, combinational from registered state.
  - ddr_wfifo_data = skid head.
  - The head pops on any clock edge with we=1.
  - Push and pop in the same cycle keep occupancy constant.
- Full asserted indefinitely: issuing stalls once the credit is exhausted. No row is lost or duplicated; skid occupancy never exceeds SKID_DEPTH.
- DRAIN: go to IDLE when no reads are in flight and the skid buffer is empty.
- idle = state==IDLE; it rises the cycle after the last row is written.
- Row order to the FIFO is strictly line 0 addresses ascending, then line 1 addresses ascending.

Test Plan:
- Basic ordering: BP_st_num=1, BP_st_addr=0x10, Line_width=3, full=0. Required: ddr_conf is one pulse; reads hit buffers 1+4j at addresses 0x10,0x11,0x12, then 2+4j at 0x10..0x12; 6 writes in order; data word j equals the buffer (bank+4j) model.
- Bank wrap: BP_st_num=3, Line_width=2. Required: line 1 reads bank 0 (BP_rd_en bits 0,4,..,60).
- Backpressure: hold ddr_wfifo_full=1 for 20 cycles mid-stream with Line_width=8. Required: at most SKID_DEPTH rows buffered, we=0 throughout the stall, all 16 rows delivered in order after release.
- Throughput: full=0, Line_width=100. Required: 200 writes in 200 consecutive cycles after the RD_LAT fill.
- Busy and zero-length: conf during READ is ignored (ddr_len unchanged). Line_width=0: ddr_conf pulse, zero writes, idle stays 1.
- Reset mid-transfer: assert rst_n=0 asynchronously at row 5. Required: outputs go to 0 and idle=1 immediately; a new conf afterwards completes normally.

Source files
------------

// File: rtl/bp_writeback_control.sv
// bp_writeback_control: streams two consecutive BP buffer banks row by row into the DDR write FIFO
// Ports: conf, data_ddr_byte, ddr_st_addr, BP_st_addr, BP_st_num and Line_width describe one transfer;
//   ddr_st_addr_out, ddr_len and ddr_conf command the DDR write engine; BP_addr_out, BP_rd_en and
//   BP_data_in read the BP buffer array; ddr_wfifo_full, ddr_wfifo_we and ddr_wfifo_data feed the
//   DDR write FIFO; idle is high when no transfer is active or pending.
module bp_writeback_control #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int BUFFER_NUM   = 64,
  parameter int RD_LAT       = 2,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           conf,
  input  logic [SINGLE_LEN-1:0]          data_ddr_byte,
  input  logic [DDR_ADDR_LEN-1:0]        ddr_st_addr,
  input  logic [ADDR_LEN-1:0]            BP_st_addr,
  input  logic [1:0]                     BP_st_num,
  input  logic [SINGLE_LEN-1:0]          Line_width,
  output logic [DDR_ADDR_LEN-1:0]        ddr_st_addr_out,
  output logic [SINGLE_LEN-1:0]          ddr_len,
  output logic                           ddr_conf,
  output logic [ADDR_LEN*BUFFER_NUM-1:0] BP_addr_out,
  output logic [BUFFER_NUM-1:0]          BP_rd_en,
  input  logic [DATA_LEN*BUFFER_NUM-1:0] BP_data_in,
  input  logic                           ddr_wfifo_full,
  output logic                           ddr_wfifo_we,
  output logic [DATA_LEN*X_MESH-1:0]     ddr_wfifo_data,
  output logic                           idle
);
  localparam int ROW_W = DATA_LEN * X_MESH;
  localparam int PW    = $clog2(SKID_DEPTH);
  localparam int CW    = $clog2(SKID_DEPTH + RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                  state_q;
  logic [DDR_ADDR_LEN-1:0] ddr_addr_q;
  logic [SINGLE_LEN-1:0]   ddr_len_q, width_q, cnt_q;
  logic                    ddr_conf_q, line_q;
  logic [ADDR_LEN-1:0]     base_q, addr_q;
  logic [1:0]              bank_q;
  logic [RD_LAT-1:0]       vld_q;
  logic [1:0]              bank_pipe_q [RD_LAT];
  logic [ROW_W-1:0]        skid_q [SKID_DEPTH];
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]           occ_q, occ_d, inflight;
  logic                    issue, push, pop, last_row;
  logic [ROW_W-1:0]        push_row;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_q[i]);
  end
  // Credit counts rows already buffered plus rows still in the read pipeline, so the skid never overflows.
  assign issue    = state_q == READ && (occ_q + inflight) < CW'(SKID_DEPTH);
  assign last_row = cnt_q == width_q - SINGLE_LEN'(1);
  assign push     = vld_q[RD_LAT-1];
  assign pop      = ddr_wfifo_we;
  assign occ_d    = occ_q + CW'(push) - CW'(pop);
  always_comb begin
    push_row = '0;
    for (int j = 0; j < X_MESH; j++)
      push_row[j*DATA_LEN +: DATA_LEN] = BP_data_in[(int'(bank_pipe_q[RD_LAT-1]) + X_MAC*j)*DATA_LEN +: DATA_LEN];
  end
  always_comb begin
    BP_rd_en = '0;
    for (int j = 0; j < X_MESH; j++) BP_rd_en[int'(bank_q) + X_MAC*j] = issue;
  end
  assign BP_addr_out     = {BUFFER_NUM{addr_q}};
  assign ddr_wfifo_we    = occ_q != '0 && !ddr_wfifo_full;
  assign ddr_wfifo_data  = skid_q[rd_ptr_q];
  assign ddr_st_addr_out = ddr_addr_q;
  assign ddr_len         = ddr_len_q;
  assign ddr_conf        = ddr_conf_q;
  assign idle            = state_q == IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ddr_addr_q <= '0;
      ddr_len_q  <= '0;
      ddr_conf_q <= 1'b0;
      width_q    <= '0;
      cnt_q      <= '0;
      line_q     <= 1'b0;
      base_q     <= '0;
      addr_q     <= '0;
      bank_q     <= '0;
      vld_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) bank_pipe_q[i] <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
    end else begin
      ddr_conf_q <= 1'b0;
      case (state_q)
        IDLE: if (conf) begin
          ddr_conf_q <= 1'b1;
          ddr_addr_q <= ddr_st_addr;
          ddr_len_q  <= data_ddr_byte;
          width_q    <= Line_width;
          base_q     <= BP_st_addr;
          addr_q     <= BP_st_addr;
          bank_q     <= BP_st_num;
          cnt_q      <= '0;
          line_q     <= 1'b0;
          state_q    <= Line_width != '0 ? READ : IDLE;
        end
        READ: if (issue) begin
          cnt_q   <= last_row ? '0 : cnt_q + SINGLE_LEN'(1);
          addr_q  <= last_row ? base_q : addr_q + ADDR_LEN'(1);
          bank_q  <= last_row ? bank_q + 2'd1 : bank_q;
          line_q  <= line_q | last_row;
          state_q <= last_row && line_q ? DRAIN : READ;
        end
        // Leave as soon as the last row pops so idle rises the cycle after the final write.
        DRAIN: state_q <= inflight == '0 && occ_d == '0 ? IDLE : DRAIN;
        default: state_q <= IDLE;
      endcase
      vld_q[0]       <= issue;
      bank_pipe_q[0] <= bank_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]       <= vld_q[i-1];
        bank_pipe_q[i] <= bank_pipe_q[i-1];
      end
      if (push) begin
        skid_q[wr_ptr_q] <= push_row;
        wr_ptr_q         <= wr_ptr_q == PW'(SKID_DEPTH-1) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q == PW'(SKID_DEPTH-1) ? '0 : rd_ptr_q + PW'(1);
      occ_q <= occ_d;
    end
  end
endmodule

// File: tb/tb_bp_writeback_control.sv
// tb_bp_writeback_control: randomized self-checking bench for bp_writeback_control
module tb_bp_writeback_control;
  localparam int DL = 32, AL = 16, BN = 64, SD = 4;
  logic clk = 0, rst_n = 0, conf = 0, ddr_wfifo_full = 0;
  logic [23:0] data_ddr_byte = 0, Line_width = 0;
  logic [31:0] ddr_st_addr = 0;
  logic [15:0] BP_st_addr = 0;
  logic [1:0] BP_st_num = 0;
  logic [31:0] ddr_st_addr_out;
  logic [23:0] ddr_len;
  logic ddr_conf, ddr_wfifo_we, idle;
  logic [AL*BN-1:0] BP_addr_out;
  logic [BN-1:0] BP_rd_en;
  logic [DL*BN-1:0] BP_data_in;
  logic [DL*16-1:0] ddr_wfifo_data;
  bp_writeback_control dut (
    .clk(clk), .rst_n(rst_n), .conf(conf), .data_ddr_byte(data_ddr_byte), .ddr_st_addr(ddr_st_addr),
    .BP_st_addr(BP_st_addr), .BP_st_num(BP_st_num), .Line_width(Line_width),
    .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
    .BP_addr_out(BP_addr_out), .BP_rd_en(BP_rd_en), .BP_data_in(BP_data_in),
    .ddr_wfifo_full(ddr_wfifo_full), .ddr_wfifo_we(ddr_wfifo_we), .ddr_wfifo_data(ddr_wfifo_data), .idle(idle)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, n_we = 0, n_rd = 0, n_conf = 0, max_pend = 0;
  int last_we_cyc = -1, idle_rise_cyc = -1;
  int we_cycs[$];
  bit prev_idle = 1;
  logic [63:0] last_rd_mask = 0;
  logic [511:0] exp_rows[$];
  logic [63:0] exp_mask[$];
  logic [15:0] exp_addr[$];
  logic [31:0] seed = 0;
  logic [15:0] a1 = 0, a2 = 0;
  logic [63:0] e1 = 0, e2 = 0;
  function automatic logic [31:0] mem(input int b, input logic [15:0] a, input logic [31:0] s);
    return (32'(b) * 32'h9E3779B1) ^ {a, ~a} ^ s;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    a1 <= BP_addr_out[15:0];
    a2 <= a1;
    e1 <= BP_rd_en;
    e2 <= e1;
  end
  always_comb begin
    BP_data_in = '0;
    for (int b = 0; b < BN; b++) BP_data_in[b*DL +: DL] = e2[b] ? mem(b, a2, seed) : ~mem(b, a2, seed);
  end
  always @(negedge clk) if (rst_n) begin
    if (ddr_conf) n_conf++;
    if (idle && !prev_idle) idle_rise_cyc = cyc;
    prev_idle = idle;
    if (ddr_wfifo_full) begin
      n_chk++;
      if (ddr_wfifo_we !== 1'b0) begin n_fail++; $display("FAIL we_during_full: we=%b required 0", ddr_wfifo_we); end
    end
    if (ddr_wfifo_we === 1'b1) begin
      logic [511:0] r;
      n_we++;
      last_we_cyc = cyc;
      we_cycs.push_back(cyc);
      n_chk++;
      if (exp_rows.size() == 0) begin
        n_fail++; $display("FAIL unexpected_write: data=%h required none", ddr_wfifo_data);
      end else begin
        r = exp_rows.pop_front();
        if (ddr_wfifo_data !== r) begin n_fail++; $display("FAIL row_data: got %h required %h", ddr_wfifo_data, r); end
      end
    end
    if (BP_rd_en !== '0) begin
      logic [63:0] m;
      logic [15:0] ea;
      bit bad;
      n_rd++;
      last_rd_mask = BP_rd_en;
      n_chk++;
      if (exp_mask.size() == 0) begin
        n_fail++; $display("FAIL unexpected_read: rd_en=%h required none", BP_rd_en);
      end else begin
        m = exp_mask.pop_front();
        ea = exp_addr.pop_front();
        bad = 0;
        for (int b = 0; b < BN; b++) if (BP_addr_out[b*AL +: AL] !== ea) bad = 1;
        if (BP_rd_en !== m || bad) begin
          n_fail++; $display("FAIL read_issue: rd_en=%h addr0=%h required rd_en=%h addr=%h (slice mismatch=%0d)", BP_rd_en, BP_addr_out[15:0], m, ea, bad);
        end
      end
    end
    if (n_rd - n_we > max_pend) max_pend = n_rd - n_we;
  end
  task automatic plan(input logic [1:0] num, input logic [15:0] base, input int w);
    logic [1:0] bk;
    logic [63:0] m;
    logic [15:0] a;
    logic [511:0] row;
    for (int l = 0; l < 2; l++) begin
      bk = num + 2'(l);
      m = '0;
      for (int j = 0; j < 16; j++) m[bk + 4*j] = 1'b1;
      for (int i = 0; i < w; i++) begin
        a = base + 16'(i);
        for (int j = 0; j < 16; j++) row[j*32 +: 32] = mem(bk + 4*j, a, seed);
        exp_rows.push_back(row);
        exp_mask.push_back(m);
        exp_addr.push_back(a);
      end
    end
  endtask
  task automatic start(input logic [1:0] num, input logic [15:0] base, input int w, output logic [31:0] ea, output logic [23:0] el);
    seed = $urandom();
    ea = $urandom();
    el = 24'($urandom());
    plan(num, base, w);
    @(posedge clk); #1;
    conf = 1; BP_st_num = num; BP_st_addr = base; Line_width = 24'(w); ddr_st_addr = ea; data_ddr_byte = el;
    @(posedge clk); #1;
    conf = 0; BP_st_num = 2'($urandom()); BP_st_addr = 16'($urandom()); Line_width = 24'($urandom()); ddr_st_addr = $urandom(); data_ddr_byte = 24'($urandom());
  endtask
  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (!(idle && exp_rows.size() == 0) && n < budget) begin
      @(posedge clk); #1;
      ddr_wfifo_full = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk); #1;
      n++;
    end
    ddr_wfifo_full = 0;
    n_chk++;
    if (n >= budget) begin n_fail++; $display("FAIL done_timeout: idle=%b rows_left=%0d after %0d cycles, required completion", idle, exp_rows.size(), n); end
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_chk++;
    if ({ddr_conf, ddr_wfifo_we, |BP_rd_en, |BP_addr_out, |ddr_wfifo_data, |ddr_st_addr_out, |ddr_len} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: conf=%b we=%b rd_en=%h len=%h addr=%h required all zero", ddr_conf, ddr_wfifo_we, BP_rd_en, ddr_len, ddr_st_addr_out);
    end
    n_chk++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: idle=%b required 1", idle); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic_order();
    int w0 = n_we, r0 = n_rd, c0 = n_conf;
    logic [31:0] ea;
    logic [23:0] el;
    start(2'd1, 16'h0010, 3, ea, el);
    n_chk++;
    if (ddr_conf !== 1'b1 || ddr_st_addr_out !== ea || ddr_len !== el) begin
      n_fail++; $display("FAIL basic_cmd: conf=%b addr=%h len=%h required 1 %h %h", ddr_conf, ddr_st_addr_out, ddr_len, ea, el);
    end
    wait_done(200, 0);
    n_chk++;
    if (n_we - w0 != 6 || n_rd - r0 != 6) begin n_fail++; $display("FAIL basic_count: writes=%0d reads=%0d required 6 6", n_we - w0, n_rd - r0); end
    n_chk++;
    if (n_conf - c0 != 1) begin n_fail++; $display("FAIL basic_conf_pulse: pulses=%0d required 1", n_conf - c0); end
    n_chk++;
    if (idle_rise_cyc != last_we_cyc + 1) begin n_fail++; $display("FAIL basic_idle_rise: cycle=%0d required %0d", idle_rise_cyc, last_we_cyc + 1); end
  endtask
  task automatic test_bank_wrap();
    int w0 = n_we;
    logic [31:0] ea;
    logic [23:0] el;
    start(2'd3, 16'($urandom()), 2, ea, el);
    wait_done(200, 0);
    n_chk++;
    if (last_rd_mask !== 64'h1111_1111_1111_1111) begin n_fail++; $display("FAIL wrap_bank0: rd_en=%h required 1111111111111111", last_rd_mask); end
    n_chk++;
    if (n_we - w0 != 4 || exp_rows.size() != 0) begin n_fail++; $display("FAIL wrap_count: writes=%0d left=%0d required 4 0", n_we - w0, exp_rows.size()); end
  endtask
  task automatic test_backpressure();
    int w0 = n_we, n = 0;
    logic [31:0] ea;
    logic [23:0] el;
    max_pend = 0;
    start(2'($urandom()), 16'($urandom()), 8, ea, el);
    while (n_we - w0 < 3 && n < 50) begin @(negedge clk); #1; n++; end
    n_chk++;
    if (n >= 50) begin n_fail++; $display("FAIL bp_start_timeout: writes=%0d required 3", n_we - w0); end
    @(posedge clk); #1;
    ddr_wfifo_full = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (ddr_wfifo_we !== 1'b0) begin n_fail++; $display("FAIL bp_stall_we: we=%b required 0", ddr_wfifo_we); end
    end
    n_chk++;
    if (n_rd - n_we != SD) begin n_fail++; $display("FAIL bp_buffered: rows=%0d required %0d", n_rd - n_we, SD); end
    wait_done(200, 0);
    n_chk++;
    if (max_pend > SD) begin n_fail++; $display("FAIL bp_max_buffered: rows=%0d required <= %0d", max_pend, SD); end
    n_chk++;
    if (n_we - w0 != 16 || exp_rows.size() != 0) begin n_fail++; $display("FAIL bp_count: writes=%0d left=%0d required 16 0", n_we - w0, exp_rows.size()); end
  endtask
  task automatic test_throughput();
    logic [31:0] ea;
    logic [23:0] el;
    we_cycs.delete();
    start(2'($urandom()), 16'($urandom()), 100, ea, el);
    wait_done(400, 0);
    n_chk++;
    if (we_cycs.size() != 200) begin
      n_fail++; $display("FAIL tput_count: writes=%0d required 200", we_cycs.size());
    end else if (we_cycs[199] - we_cycs[0] != 199) begin
      n_fail++; $display("FAIL tput_span: span=%0d required 199", we_cycs[199] - we_cycs[0]);
    end
  endtask
  task automatic test_busy_zero();
    int w0 = n_we, r0, c0 = n_conf;
    logic [31:0] ea;
    logic [23:0] el;
    start(2'($urandom()), 16'($urandom()), 10, ea, el);
    repeat (3) @(posedge clk);
    #1;
    conf = 1; data_ddr_byte = ~el; ddr_st_addr = ~ea; Line_width = 24'd5;
    @(posedge clk); #1;
    conf = 0;
    n_chk++;
    if (ddr_conf !== 1'b0 || ddr_len !== el || ddr_st_addr_out !== ea) begin
      n_fail++; $display("FAIL busy_conf: conf=%b len=%h addr=%h required 0 %h %h", ddr_conf, ddr_len, ddr_st_addr_out, el, ea);
    end
    wait_done(200, 0);
    n_chk++;
    if (n_we - w0 != 20 || n_conf - c0 != 1) begin n_fail++; $display("FAIL busy_count: writes=%0d pulses=%0d required 20 1", n_we - w0, n_conf - c0); end
    w0 = n_we; r0 = n_rd; c0 = n_conf;
    start(2'($urandom()), 16'($urandom()), 0, ea, el);
    n_chk++;
    if (ddr_conf !== 1'b1 || ddr_len !== el) begin n_fail++; $display("FAIL zero_cmd: conf=%b len=%h required 1 %h", ddr_conf, ddr_len, el); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (idle !== 1'b1 || ddr_wfifo_we !== 1'b0 || BP_rd_en !== '0) begin
        n_fail++; $display("FAIL zero_quiet: idle=%b we=%b rd_en=%h required 1 0 0", idle, ddr_wfifo_we, BP_rd_en);
      end
    end
    n_chk++;
    if (n_we != w0 || n_rd != r0 || n_conf - c0 != 1) begin
      n_fail++; $display("FAIL zero_count: writes=%0d reads=%0d pulses=%0d required 0 0 1", n_we - w0, n_rd - r0, n_conf - c0);
    end
  endtask
  task automatic test_reset_mid();
    int w0 = n_we, r0, n = 0;
    logic [31:0] ea;
    logic [23:0] el;
    start(2'($urandom()), 16'($urandom()), 8, ea, el);
    while (n_we - w0 < 5 && n < 100) begin @(negedge clk); #1; n++; end
    n_chk++;
    if (n >= 100) begin n_fail++; $display("FAIL rstmid_timeout: writes=%0d required 5", n_we - w0); end
    #1 rst_n = 0;
    #1;
    n_chk++;
    if ({ddr_conf, ddr_wfifo_we, |BP_rd_en, |BP_addr_out, |ddr_wfifo_data, |ddr_st_addr_out, |ddr_len} !== 7'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: conf=%b we=%b rd_en=%h len=%h required all zero", ddr_conf, ddr_wfifo_we, BP_rd_en, ddr_len);
    end
    n_chk++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: idle=%b required 1", idle); end
    exp_rows.delete(); exp_mask.delete(); exp_addr.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    w0 = n_we; r0 = n_rd;
    start(2'($urandom()), 16'($urandom()), 4, ea, el);
    n_chk++;
    if (ddr_conf !== 1'b1 || ddr_len !== el) begin n_fail++; $display("FAIL rstmid_cmd: conf=%b len=%h required 1 %h", ddr_conf, ddr_len, el); end
    wait_done(200, 0);
    n_chk++;
    if (n_we - w0 != 8 || n_rd - r0 != 8) begin n_fail++; $display("FAIL rstmid_count: writes=%0d reads=%0d required 8 8", n_we - w0, n_rd - r0); end
  endtask
  task automatic test_random();
    int w0, w;
    logic [31:0] ea;
    logic [23:0] el;
    for (int k = 0; k < 6; k++) begin
      w0 = n_we;
      w = $urandom_range(1, 12);
      start(2'($urandom()), 16'($urandom()), w, ea, el);
      wait_done(400, 1);
      n_chk++;
      if (n_we - w0 != 2*w || exp_rows.size() != 0) begin
        n_fail++; $display("FAIL random_count: writes=%0d left=%0d required %0d 0", n_we - w0, exp_rows.size(), 2*w);
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic_order();
    test_bank_wrap();
    test_backpressure();
    test_throughput();
    test_busy_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
